psg_cmd_encoder: RTL and testbench
==================================

PSG_CMD_ENCODER -- requirements
Module: psg_cmd_encoder

Interface
REQ-001 Parameter HOLD_CYCLES, default 2: number of clk cycles each emitted byte is driven before the next byte may appear (legal 1..15).
REQ-002 Parameter FIFO_DEPTH, default 4: command buffer entries (power of two, >=2).
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command offered this cycle.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_chan  input  2  target channel; 0-2 tone, 3 noise.
REQ-008 cmd_attn  input  1  1 = attenuation write, 0 = frequency/noise-control write.
REQ-009 cmd_value  input  10  payload; attn uses [3:0], tone uses [9:0], noise uses [2:0].
REQ-010 bus_out  output  8  byte stream to PSG data input; sampled by the PSG on every clk.
REQ-011 byte_strobe  output  1  one-cycle pulse on the first cycle a new byte is on bus_out.
REQ-012 busy  output  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-013 Commands SHALL be buffered in a FIFO_DEPTH-entry FIFO; cmd_ready = FIFO not full.
REQ-014 Push and pop in the same cycle SHALL be allowed; count unchanged; no entry lost or duplicated.
REQ-015 When FIFO is full, cmd_ready SHALL be 0 and cmd_valid SHALL be ignored.
REQ-016 FSM states SHALL be IDLE, LATCH, DATA, NOISE_CLR.
REQ-017 IDLE with FIFO non-empty: pop head, load latch byte onto bus_out on the next edge, go LATCH, pulse byte_strobe.
REQ-018 Latch byte SHALL be {1, cmd_chan, cmd_attn, nibble}; nibble = value[3:0] for attn and tone, {0, value[2:0]} for noise control (chan 3, attn 0).
REQ-019 LATCH SHALL hold bus_out for HOLD_CYCLES cycles via a hold counter, except noise control, which is held exactly 1 cycle.
REQ-020 After LATCH: tone (chan 0-2, attn 0) -> DATA; noise control -> NOISE_CLR; attenuation -> IDLE.
REQ-021 DATA SHALL drive {0, 0, value[9:4]} for HOLD_CYCLES cycles, pulse byte_strobe on entry, then go IDLE.
REQ-022 NOISE_CLR SHALL drive 0x00 (harmless data byte while latch selects noise) for HOLD_CYCLES cycles, pulse byte_strobe on entry, then go IDLE; ensures noise LFSR reset asserts for one cycle only.
REQ-023 In IDLE, bus_out SHALL keep the last emitted byte (re-writes are idempotent).
REQ-024 Back-to-back: if FIFO non-empty when a state's hold expires, the next command's latch byte SHALL appear on the following edge (no idle bubble).
REQ-025 cmd_value bits unused by a command type SHALL be ignored.
REQ-026 Tone latch and data bytes SHALL be emitted consecutively; no other byte may be interleaved.
REQ-027 byte_strobe SHALL be 0 in all cycles other than those in REQ-017, REQ-021, REQ-022.
REQ-028 Per-command byte time: attn HOLD_CYCLES; tone 2*HOLD_CYCLES; noise 1+HOLD_CYCLES.

Reset
REQ-029 On reset: FSM = IDLE, FIFO empty, hold counter 0, bus_out = 0x00, byte_strobe = 0, busy = 0, cmd_ready = 1.
REQ-030 Reset mid-command SHALL abort the sequence and flush the FIFO; no partial byte after reset deasserts.
REQ-031 cmd_valid during reset SHALL be ignored.

Verification
REQ-032 Attn: push chan 1, attn 1, value 0x005 -> bus_out 0xB5 for 2 cycles, one strobe, busy falls after.
REQ-033 Tone: push chan 2, attn 0, value 0x3A7 -> 0xC7 for 2 cycles then 0x3A for 2 cycles, two strobes, bus holds 0x3A in IDLE.
REQ-034 Noise: push chan 3, attn 0, value 0x005 -> 0xE5 for exactly 1 cycle then 0x00 for 2 cycles.
REQ-035 Full FIFO: push 5 commands with no gaps, HOLD_CYCLES=2 -> cmd_ready low after 4th-while-busy, 5th accepted once a slot frees; all bytes in order, no bubbles.
REQ-036 Reset during DATA of tone 0x3A7 -> bus_out 0x00 next cycle, busy 0, queued commands never emitted.
REQ-037 Push and pop same cycle with FIFO at 1 entry -> count stays 1, command order preserved.

Source files
------------

// File: rtl/psg_cmd_encoder_if.sv
// Command handshake between a host and psg_cmd_encoder.
// The host drives the valid, channel, type and payload signals; the encoder returns ready.
interface psg_cmd_encoder_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_chan;
  logic       cmd_attn;
  logic [9:0] cmd_value;

  modport master (
    output cmd_valid, cmd_chan, cmd_attn, cmd_value,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_chan, cmd_attn, cmd_value,
    output cmd_ready
  );
endinterface

// File: rtl/psg_cmd_encoder.sv
// Buffers PSG register commands and serialises them into timed latch/data byte writes.
// A tone write becomes a latch byte plus a data byte; noise control is followed by a 0x00 byte.
module psg_cmd_encoder #(
  parameter int HOLD_CYCLES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  psg_cmd_encoder_if.slave  cmd,
  output logic [7:0]        bus_out,
  output logic              byte_strobe,
  output logic              busy
);
  localparam int         PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LATCH, DATA, NOISE_CLR} state_t;
  typedef enum logic [1:0] {K_ATTN, K_TONE, K_NOISE} kind_t;
  typedef struct packed {
    logic [1:0] chan;
    logic       attn;
    logic [9:0] value;
  } cmd_t;

  cmd_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop;
  cmd_t             head;
  kind_t            head_kind;
  logic [7:0]       head_latch;

  state_t     state, state_nxt;
  kind_t      kind, kind_nxt;
  logic [5:0] data_hi, data_hi_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic [7:0] bus_nxt;
  logic       strobe_nxt;
  logic       advance;

  assign cmd.cmd_ready = (count != (PTR_W+1)'(FIFO_DEPTH));
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign busy          = (count != '0) || (state != IDLE);

  // Decode the FIFO head into its byte sequence and the latch byte it opens with.
  assign head       = mem[rd_ptr];
  assign head_kind  = head.attn ? K_ATTN : ((head.chan == 2'd3) ? K_NOISE : K_TONE);
  assign head_latch = {1'b1, head.chan, head.attn,
                       (head_kind == K_NOISE) ? {1'b0, head.value[2:0]} : head.value[3:0]};

  // NOTE: storage carries no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{chan: cmd.cmd_chan, attn: cmd.cmd_attn, value: cmd.cmd_value};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt   = state;
    kind_nxt    = kind;
    data_hi_nxt = data_hi;
    hold_nxt    = hold_cnt;
    bus_nxt     = bus_out;
    strobe_nxt  = 1'b0;
    pop         = 1'b0;
    advance     = 1'b0;

    unique case (state)
      IDLE: advance = 1'b1;
      LATCH: begin
        if (hold_cnt != 4'd0) begin
          hold_nxt = hold_cnt - 4'd1;
        end else begin
          unique case (kind)
            K_TONE: begin
              state_nxt  = DATA;
              bus_nxt    = {2'b00, data_hi};
              strobe_nxt = 1'b1;
              hold_nxt   = HOLD_LOAD;
            end
            K_NOISE: begin
              state_nxt  = NOISE_CLR;
              bus_nxt    = 8'h00;
              strobe_nxt = 1'b1;
              hold_nxt   = HOLD_LOAD;
            end
            default: advance = 1'b1;
          endcase
        end
      end
      DATA, NOISE_CLR: begin
        if (hold_cnt != 4'd0) hold_nxt = hold_cnt - 4'd1;
        else                  advance  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // A finished sequence chains straight into the next queued command.
    if (advance) begin
      if (count != '0) begin
        pop         = 1'b1;
        state_nxt   = LATCH;
        kind_nxt    = head_kind;
        data_hi_nxt = head.value[9:4];
        bus_nxt     = head_latch;
        strobe_nxt  = 1'b1;
        hold_nxt    = (head_kind == K_NOISE) ? 4'd0 : HOLD_LOAD;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      kind        <= K_ATTN;
      data_hi     <= '0;
      hold_cnt    <= '0;
      bus_out     <= 8'h00;
      byte_strobe <= 1'b0;
    end else begin
      state       <= state_nxt;
      kind        <= kind_nxt;
      data_hi     <= data_hi_nxt;
      hold_cnt    <= hold_nxt;
      bus_out     <= bus_nxt;
      byte_strobe <= strobe_nxt;
    end
  end
endmodule

// File: tb/tb_psg_cmd_encoder.sv
// Directed bench for psg_cmd_encoder (HOLD_CYCLES=2, FIFO_DEPTH=4).
// Outputs are sampled 1 time unit after each rising edge.
module tb_psg_cmd_encoder;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bus_out;
  logic       byte_strobe;
  logic       busy;
  int         vectors    = 0;
  int         miscompares = 0;

  psg_cmd_encoder_if cmd_if ();

  psg_cmd_encoder #(.HOLD_CYCLES(2), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd_if.slave),
    .bus_out    (bus_out),
    .byte_strobe(byte_strobe),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Six commands that overfill the FIFO, with per-edge expectations for E0..E18.
  logic [1:0] s_chan [6] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd0};
  logic       s_attn [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [9:0] s_val  [6] = '{10'h2C3, 10'h3F9, 10'h006, 10'h155, 10'h00E, 10'h001};
  logic [7:0] e_bus  [19] = '{8'h00, 8'h83, 8'h83, 8'h2C, 8'h2C, 8'hB9, 8'hB9, 8'hE6, 8'h00, 8'h00,
                              8'hC5, 8'hC5, 8'h15, 8'h15, 8'hFE, 8'hFE, 8'h91, 8'h91, 8'h91};
  logic       e_stb  [19] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                              1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       e_rdy  [19] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic valid, input logic [1:0] chan, input logic attn, input logic [9:0] value);
    cmd_if.cmd_valid = valid;
    cmd_if.cmd_chan  = chan;
    cmd_if.cmd_attn  = attn;
    cmd_if.cmd_value = value;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idx;
    logic acc;

    // Reset with a command offered; it must be ignored.
    reset = 1'b1;
    drive(1'b1, 2'd1, 1'b1, 10'h005);
    tick();
    tick();
    reset = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 10'h000);
    check("rst_bus", bus_out, 8'h00);
    check("rst_strobe", byte_strobe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", cmd_if.cmd_ready, 1'b1);
    tick();
    check("rst_ignored_busy", busy, 1'b0);
    check("rst_ignored_bus", bus_out, 8'h00);

    // Attenuation: chan 1, value 5 -> 0xB5 for two cycles.
    drive(1'b1, 2'd1, 1'b1, 10'h005);
    tick();
    drive(1'b0, 2'd0, 1'b0, 10'h000);
    check("attn_queued_busy", busy, 1'b1);
    check("attn_queued_strobe", byte_strobe, 1'b0);
    tick();
    check("attn_b0_bus", bus_out, 8'hB5);
    check("attn_b0_strobe", byte_strobe, 1'b1);
    tick();
    check("attn_b1_bus", bus_out, 8'hB5);
    check("attn_b1_strobe", byte_strobe, 1'b0);
    check("attn_b1_busy", busy, 1'b1);
    tick();
    check("attn_idle_busy", busy, 1'b0);
    check("attn_idle_bus", bus_out, 8'hB5);
    check("attn_idle_strobe", byte_strobe, 1'b0);

    // Tone: chan 2, value 0x3A7 -> 0xC7 x2 then 0x3A x2, bus keeps 0x3A.
    drive(1'b1, 2'd2, 1'b0, 10'h3A7);
    tick();
    drive(1'b0, 2'd0, 1'b0, 10'h000);
    tick();
    check("tone_l0_bus", bus_out, 8'hC7);
    check("tone_l0_strobe", byte_strobe, 1'b1);
    tick();
    check("tone_l1_bus", bus_out, 8'hC7);
    check("tone_l1_strobe", byte_strobe, 1'b0);
    tick();
    check("tone_d0_bus", bus_out, 8'h3A);
    check("tone_d0_strobe", byte_strobe, 1'b1);
    tick();
    check("tone_d1_bus", bus_out, 8'h3A);
    check("tone_d1_strobe", byte_strobe, 1'b0);
    tick();
    check("tone_idle_bus", bus_out, 8'h3A);
    check("tone_idle_busy", busy, 1'b0);

    // Noise: chan 3, value 0x3FD (upper bits ignored) -> 0xE5 x1 then 0x00 x2.
    drive(1'b1, 2'd3, 1'b0, 10'h3FD);
    tick();
    drive(1'b0, 2'd0, 1'b0, 10'h000);
    tick();
    check("noise_l_bus", bus_out, 8'hE5);
    check("noise_l_strobe", byte_strobe, 1'b1);
    tick();
    check("noise_c0_bus", bus_out, 8'h00);
    check("noise_c0_strobe", byte_strobe, 1'b1);
    tick();
    check("noise_c1_bus", bus_out, 8'h00);
    check("noise_c1_strobe", byte_strobe, 1'b0);
    tick();
    check("noise_idle_busy", busy, 1'b0);
    check("noise_idle_bus", bus_out, 8'h00);

    // Back-to-back stream that fills the FIFO; cmd_valid stays high until all six are taken.
    idx = 0;
    for (int c = 0; c < 19; c++) begin
      if (idx < 6) drive(1'b1, s_chan[idx], s_attn[idx], s_val[idx]);
      else         drive(1'b0, 2'd0, 1'b0, 10'h000);
      acc = cmd_if.cmd_valid && cmd_if.cmd_ready;
      tick();
      if (acc) idx++;
      check($sformatf("stream_bus_e%0d", c), bus_out, e_bus[c]);
      check($sformatf("stream_strobe_e%0d", c), byte_strobe, e_stb[c]);
      check($sformatf("stream_ready_e%0d", c), cmd_if.cmd_ready, e_rdy[c]);
    end
    check("stream_all_accepted", idx, 6);
    check("stream_done_busy", busy, 1'b0);

    // Reset during the DATA byte of a tone with two commands still queued.
    drive(1'b1, 2'd2, 1'b0, 10'h3A7);
    tick();
    drive(1'b1, 2'd0, 1'b1, 10'h001);
    tick();
    drive(1'b1, 2'd1, 1'b1, 10'h00C);
    tick();
    drive(1'b0, 2'd0, 1'b0, 10'h000);
    tick();
    check("rstmid_data_bus", bus_out, 8'h3A);
    check("rstmid_data_strobe", byte_strobe, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_bus", bus_out, 8'h00);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_ready", cmd_if.cmd_ready, 1'b1);
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("rstmid_quiet_bus_%0d", c), bus_out, 8'h00);
      check($sformatf("rstmid_quiet_strobe_%0d", c), byte_strobe, 1'b0);
      check($sformatf("rstmid_quiet_busy_%0d", c), busy, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
